// File: rtl/xdisplay_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller:
// digit-word field positions and scan FSM states.
package xdisplay_ctrl_pkg;

  localparam int DISPLAY_W   = 7;
  localparam int DIG_VAL_MSB = 3;
  localparam int DIG_BLANK   = 4;
  localparam int DIG_BLINK   = 5;
  localparam int DIG_DP      = 6;

  localparam logic [DISPLAY_W-1:0] DIG_RST = 7'b0010000;

  typedef enum logic [0:0] {
    XDISP_GUARD = 1'b0,
    XDISP_DRIVE = 1'b1
  } xdisp_state_e;

endpackage

// File: rtl/xdisplay_ctrl_xseg_decode.sv
// Hex value to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational.
module xseg_decode (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_val)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/xdisplay_ctrl.sv
// Four-digit multiplexed seven-segment controller with guard
// gaps between digits and a shared blink phase.
module xdisplay_ctrl
  import xdisplay_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD_CYC = 500,
  parameter int BLINK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        display_sel,
  input  logic [DATA_W-1:0] data_in,
  output logic [6:0]        seg_out,
  output logic              dp_out,
  output logic [3:0]        an_out
);

  localparam int CMAX = (SCAN_DIV > GUARD_CYC) ?
                        SCAN_DIV : GUARD_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  xdisp_state_e         r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [1:0]           r_idx, w_idx_nxt;
  logic [DISPLAY_W-1:0] r_dig [4];
  logic [DISPLAY_W-1:0] w_dig_nxt [4];
  logic [BW-1:0]        r_bcnt, w_bcnt_nxt;
  logic                 r_phase, w_phase_nxt;
  logic                 w_last;
  logic [DISPLAY_W-1:0] w_cur;
  logic [6:0]           w_hex;
  logic                 w_dark;
  logic [6:0]           w_seg_nxt;
  logic                 w_dp_nxt;
  logic [3:0]           w_an_nxt;
  logic                 w_unused_data;

  assign w_unused_data = ^data_in[DATA_W-1:DISPLAY_W];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_last      = (r_state == XDISP_GUARD) ?
                  (r_cnt == CW'(GUARD_CYC - 1)) :
                  (r_cnt == CW'(SCAN_DIV - 1));
    if (w_last) begin
      w_cnt_nxt = '0;
      if (r_state == XDISP_GUARD) begin
        w_state_nxt = XDISP_DRIVE;
      end else begin
        w_state_nxt = XDISP_GUARD;
        w_idx_nxt   = r_idx + 2'd1;
      end
    end
  end

  always_comb begin
    w_bcnt_nxt  = r_bcnt + 1'b1;
    w_phase_nxt = r_phase;
    if (r_bcnt == BW'(BLINK_DIV - 1)) begin
      w_bcnt_nxt  = '0;
      w_phase_nxt = ~r_phase;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_dig_nxt[i] = display_sel[i] ?
                     data_in[DISPLAY_W-1:0] : r_dig[i];
    end
  end

  // Outputs look at next-cycle values so writes show immediately
  assign w_cur  = w_dig_nxt[w_idx_nxt];
  assign w_dark = w_cur[DIG_BLANK] |
                  (w_cur[DIG_BLINK] & w_phase_nxt);

  xseg_decode u_dec (
    .i_val (w_cur[DIG_VAL_MSB:0]),
    .o_seg (w_hex)
  );

  always_comb begin
    w_an_nxt  = 4'hF;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if (w_state_nxt == XDISP_DRIVE) begin
      w_an_nxt = ~(4'b0001 << w_idx_nxt);
      if (!w_dark) begin
        w_seg_nxt = w_hex;
        w_dp_nxt  = ~w_cur[DIG_DP];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= XDISP_GUARD;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      for (int i = 0; i < 4; i++) r_dig[i] <= DIG_RST;
      an_out  <= 4'hF;
      seg_out <= 7'h7F;
      dp_out  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_phase <= w_phase_nxt;
      for (int i = 0; i < 4; i++) r_dig[i] <= w_dig_nxt[i];
      an_out  <= w_an_nxt;
      seg_out <= w_seg_nxt;
      dp_out  <= w_dp_nxt;
    end
  end

endmodule

// File: tb/tb_xdisplay_ctrl.sv
// Scoreboard bench for xdisplay_ctrl: a timeline model predicts
// anode/segment/dp every cycle, a monitor compares at negedge.
module tb_xdisplay_ctrl;

  localparam int S = 8;
  localparam int G = 2;
  localparam int B = 32;
  localparam int P = 4 * (S + G);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] data = 32'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  logic [11:0] q[$];
  logic [6:0]  mdig[4];
  int          k = 0;

  xdisplay_ctrl #(
    .DATA_W(32), .SCAN_DIV(S),
    .GUARD_CYC(G), .BLINK_DIV(B)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .display_sel(sel), .data_in(data),
    .seg_out(seg), .dp_out(dp), .an_out(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] t[16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
          7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
          7'h06, 7'h0E};
    return t[v];
  endfunction

  // k = rising edges since reset release; slot timeline from that
  function automatic logic [11:0] expect_out();
    int qq, d, r;
    logic [6:0] w;
    logic off;
    qq = ((k % P) + P - G) % P;
    d  = qq / (S + G);
    r  = qq % (S + G);
    if (r >= S) return {4'hF, 7'h7F, 1'b1};
    w   = mdig[d];
    off = w[4] || (w[5] && ((k / B) % 2 == 1));
    return {~(4'b0001 << d),
            off ? 7'h7F : hex7(w[3:0]),
            off ? 1'b1 : ~w[6]};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
        for (int i = 0; i < 4; i++) mdig[i] = 7'h10;
      end else begin
        k++;
        for (int i = 0; i < 4; i++)
          if (sel[i]) mdig[i] = data[6:0];
      end
      q.push_back(expect_out());
    end
  end

  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({an, seg, dp} !== e) begin
          errors++;
          $display("FAIL out k=%0d an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                   k, an, seg, dp, e[11:8], e[7:1], e[0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] s, input logic [6:0] d);
    sel  = s;
    data = {$urandom, d};
    tick(1);
    sel  = 4'h0;
  endtask

  task automatic wait_an(input logic [3:0] t);
    for (int i = 0; i < 2 * P; i++) begin
      if (an == t) break;
      tick(1);
    end
    checks++;
    if (an != t) begin
      errors++;
      $display("FAIL wait_an got=%h want=%h", an, t);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(P);
    wr(4'b0001, 7'h00);
    wr(4'b0010, 7'h01);
    wr(4'b0100, 7'h4A);
    wr(4'b1000, 7'h0F);
    tick(2 * P);
    wr(4'b0100, 7'h18);
    tick(P);
    wr(4'b0001, 7'h23);
    tick(3 * P);
    wait_an(4'hD);
    wr(4'b1111, 7'h08);
    tick(P);
    wait_an(4'hB);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2 * P);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        sel  = 4'($urandom_range(0, 15));
        data = $urandom;
      end else begin
        sel = 4'h0;
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    sel   = 4'h0;
    rst_n = 1'b1;
    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
